uart_rx_loader: RTL and testbench
=================================

Name: uart_rx_loader

Overview:
Frame controller behind a byte-wide UART receiver (8-bit words, one word per frame).
- Parses the incoming byte stream into command frames and assembles payload bytes into W_OUT-bit words.
- Routes each word to one of NUM_DEST downstream consumers over a valid/ready handshake.
- Validates each frame with an XOR checksum and a silence timeout, and reports one status pulse per frame.

Parameters:
BITS_PER_WORD, 8, bits per received byte; fixed at 8, since the header and checksum formats depend on it
W_OUT, 24, output word width; must be a multiple of BITS_PER_WORD; BYTES = W_OUT/BITS_PER_WORD
NUM_DEST, 3, number of valid destinations (1..4)
TIMEOUT_CLKS, 1024, maximum clocks between bytes inside a frame

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_valid  in  1  one-cycle pulse, byte available (no backpressure possible)
s_data  in  BITS_PER_WORD  received byte
m_valid  out  1  output word valid
m_ready  in  1  downstream accepts word
m_data  out  W_OUT  assembled word
m_dest  out  2  destination index of m_data
m_last  out  1  m_data is the final word of its frame
f_valid  out  1  one-cycle frame-status pulse
f_err  out  3  0 OK, 1 CHECKSUM, 2 TIMEOUT, 3 OVERRUN, 4 BAD_DEST
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters and checksum 0. Reset mid-frame drops the frame and any pending output word, with no f_valid.
- Frame format: HDR, then len*BYTES payload bytes, then CHK.
  - HDR[7:6] = dest; HDR[5:0] = len-1, so len is 1..64 words.
  - Payload is little-endian within a word: the first byte lands in m_data[7:0].
  - Frame is valid when the XOR of HDR, all payload bytes and CHK equals 0.
- States: IDLE, PAYLOAD, DISCARD, CHECK.
  - IDLE, s_valid: latch dest/len, init checksum=HDR. Go to PAYLOAD if dest<NUM_DEST, else DISCARD.
  - PAYLOAD: shift each byte into the assembly register. On byte BYTES-1 of a word:
    - If the output register is free, or freed in this same cycle (m_valid&&m_ready), load m_data/m_dest. Set m_last when word count == len-1.
    - m_valid rises the cycle after the completing s_valid.
    - After the last word, go to CHECK.
  - PAYLOAD overrun: a word completes while m_valid&&!m_ready. Drop the new word, f_valid with f_err=3, go to IDLE. The held word stays valid until accepted.
  - DISCARD: count len*BYTES+1 bytes without driving outputs, then f_valid with f_err=4, go to IDLE.
  - CHECK, s_valid: f_valid on the next cycle with f_err=0 if the checksum is 0, else 1. Go to IDLE.
- Timeout: in PAYLOAD, DISCARD and CHECK, a silence counter resets on every s_valid.
  - When it reaches TIMEOUT_CLKS-1: f_valid with f_err=2, go to IDLE, clear the partial word.
  - IDLE never times out.
- Words already issued are not retracted. Downstream discards a frame whose f_err != 0.
- m_valid stays high and m_data/m_dest/m_last stay stable until m_ready. Transfer occurs when m_valid&&m_ready.
- f_valid is exactly one cycle. At most one f_valid per frame.
- A byte arriving in the cycle f_valid fires (state already IDLE) is treated as the next HDR.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, PAYLOAD, DISCARD, CHECK};
  - err enum {ERR_OK, ERR_CHECKSUM, ERR_TIMEOUT, ERR_OVERRUN, ERR_BAD_DEST};
  - HDR field positions (DEST_MSB=7, DEST_LSB=6, LEN_MSB=5).
- No sub-module. Byte/word/silence counters and the checksum live inline in one FSM.

Test Plan:
1. Good frame, m_ready=1, W_OUT=24: bytes 41,11,22,33,44,55,66,36 (hex).
   - Expect m_data=0x332211 (dest 1, last 0), then 0x665544 (dest 1, last 1).
   - Expect f_valid with f_err=0 one cycle after byte 36.
2. Same frame with CHK=00.
   - Both words still emitted, then f_err=1.
3. HDR 00, one payload byte 11, then TIMEOUT_CLKS idle clocks.
   - Expect f_err=2, no m_valid, busy=0 afterwards.
4. m_ready=0, frame 01,AA,BB,CC,DD,EE,FF.
   - Word 0xCCBBAA held valid.
   - f_err=3 one cycle after FF; 0xFFEEDD never appears.
   - Raising m_ready transfers 0xCCBBAA once.
5. NUM_DEST=3, frame C0,01,02,03,C2.
   - No m_valid; f_err=4 after C2.
   - Good frame from scenario 1 then passes with f_err=0.
6. rst pulse after payload byte 44 of scenario 1.
   - All outputs 0, no f_valid.
   - Fresh scenario 1 frame passes.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, frame error codes and header field positions
package uart_pkg;
  typedef enum logic [1:0] {IDLE, PAYLOAD, DISCARD, CHECK} state_e;
  typedef enum logic [2:0] {ERR_OK, ERR_CHECKSUM, ERR_TIMEOUT, ERR_OVERRUN, ERR_BAD_DEST} err_e;
  localparam int DEST_MSB = 7;
  localparam int DEST_LSB = 6;
  localparam int LEN_MSB = 5;
endpackage

// File: rtl/uart_rx_loader.sv
// uart_rx_loader: parses UART byte frames into routed words with checksum/timeout status
module uart_rx_loader
  import uart_pkg::*;
#(
  parameter int BITS_PER_WORD = 8,
  parameter int W_OUT = 24,
  parameter int NUM_DEST = 3,
  parameter int TIMEOUT_CLKS = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  input  logic [BITS_PER_WORD-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [W_OUT-1:0]         m_data,
  output logic [1:0]               m_dest,
  output logic                     m_last,
  output logic                     f_valid,
  output logic [2:0]               f_err,
  output logic                     busy
);
  localparam int BYTES = W_OUT / BITS_PER_WORD;
  localparam int BW = BYTES > 1 ? $clog2(BYTES) : 1;
  localparam int DW = $clog2(64 * BYTES + 2);
  localparam int SW = $clog2(TIMEOUT_CLKS);

  state_e                     state_q, state_d;
  err_e                       f_err_q, f_err_d;
  logic [1:0]                 dest_q, dest_d, m_dest_q, m_dest_d;
  logic [LEN_MSB:0]           len_q, len_d, word_cnt_q, word_cnt_d;
  logic [BW-1:0]              byte_cnt_q, byte_cnt_d;
  logic [DW-1:0]              disc_cnt_q, disc_cnt_d, disc_last;
  logic [SW-1:0]              sil_q, sil_d;
  logic [BITS_PER_WORD-1:0]   chk_q, chk_d;
  logic [W_OUT-BITS_PER_WORD-1:0] asm_q, asm_d;
  logic [W_OUT-1:0]           m_data_q, m_data_d, word_next;
  logic                       m_valid_q, m_valid_d, m_last_q, m_last_d, f_valid_q, f_valid_d;
  logic                       timeout, word_done, out_free, last_word, dest_ok, disc_done;

  assign timeout   = state_q != IDLE && !s_valid && sil_q == SW'(TIMEOUT_CLKS - 1);
  assign word_done = s_valid && byte_cnt_q == BW'(BYTES - 1);
  assign out_free  = !m_valid_q || m_ready;
  assign last_word = word_cnt_q == len_q;
  assign dest_ok   = {1'b0, s_data[DEST_MSB:DEST_LSB]} < 3'(NUM_DEST);
  assign disc_last = DW'((int'(len_q) + 1) * BYTES);
  assign disc_done = s_valid && disc_cnt_q == disc_last;
  assign word_next = {s_data, asm_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      f_err_q    <= ERR_OK;
      dest_q     <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      disc_cnt_q <= '0;
      sil_q      <= '0;
      chk_q      <= '0;
      asm_q      <= '0;
      m_data_q   <= '0;
      m_dest_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      f_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      f_err_q    <= f_err_d;
      dest_q     <= dest_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      sil_q      <= sil_d;
      chk_q      <= chk_d;
      asm_q      <= asm_d;
      m_data_q   <= m_data_d;
      m_dest_q   <= m_dest_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      f_valid_q  <= f_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = s_valid ? (dest_ok ? PAYLOAD : DISCARD) : IDLE;
      PAYLOAD: state_d = timeout || (word_done && !out_free) ? IDLE
                       : (word_done && last_word) ? CHECK : PAYLOAD;
      DISCARD: state_d = timeout || disc_done ? IDLE : DISCARD;
      CHECK:   state_d = timeout || s_valid ? IDLE : CHECK;
    endcase
  end

  always_comb begin
    dest_d     = dest_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    disc_cnt_d = disc_cnt_q;
    chk_d      = chk_q;
    asm_d      = asm_q;
    m_data_d   = m_data_q;
    m_dest_d   = m_dest_q;
    m_last_d   = m_last_q;
    m_valid_d  = m_valid_q && !m_ready;
    f_valid_d  = 1'b0;
    f_err_d    = ERR_OK;
    sil_d      = s_valid || state_q == IDLE ? '0 : sil_q + 1'b1;
    unique case (state_q)
      IDLE: if (s_valid) begin
        dest_d     = s_data[DEST_MSB:DEST_LSB];
        len_d      = s_data[LEN_MSB:0];
        chk_d      = s_data;
        word_cnt_d = '0;
        byte_cnt_d = '0;
        disc_cnt_d = '0;
        asm_d      = '0;
      end
      PAYLOAD: if (timeout) begin
        f_valid_d  = 1'b1;
        f_err_d    = ERR_TIMEOUT;
        asm_d      = '0;
        byte_cnt_d = '0;
      end else if (s_valid) begin
        chk_d      = chk_q ^ s_data;
        asm_d      = word_next[W_OUT-1:BITS_PER_WORD];
        byte_cnt_d = word_done ? '0 : byte_cnt_q + 1'b1;
        if (word_done && out_free) begin
          m_valid_d  = 1'b1;
          m_data_d   = word_next;
          m_dest_d   = dest_q;
          m_last_d   = last_word;
          word_cnt_d = word_cnt_q + 1'b1;
        end else if (word_done) begin
          f_valid_d = 1'b1;
          f_err_d   = ERR_OVERRUN;
          asm_d     = '0;
        end
      end
      DISCARD: begin
        disc_cnt_d = s_valid ? disc_cnt_q + 1'b1 : disc_cnt_q;
        f_valid_d  = timeout || disc_done;
        f_err_d    = timeout ? ERR_TIMEOUT : disc_done ? ERR_BAD_DEST : ERR_OK;
      end
      CHECK: begin
        f_valid_d = timeout || s_valid;
        f_err_d   = timeout ? ERR_TIMEOUT : !s_valid ? ERR_OK
                  : (chk_q ^ s_data) == '0 ? ERR_OK : ERR_CHECKSUM;
      end
    endcase
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_dest  = m_dest_q;
  assign m_last  = m_last_q;
  assign f_valid = f_valid_q;
  assign f_err   = f_err_q;
  assign busy    = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_loader.sv
// tb_uart_rx_loader: scoreboard bench for frame parsing, routing and error reporting
module tb_uart_rx_loader;
  import uart_pkg::*;
  localparam int W_OUT = 24;
  localparam int NUM_DEST = 3;
  localparam int TIMEOUT_CLKS = 1024;
  localparam int BYTES = W_OUT / 8;

  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, m_ready = 1'b1;
  logic [7:0] s_data = '0;
  logic m_valid, m_last, f_valid, busy;
  logic [W_OUT-1:0] m_data;
  logic [1:0] m_dest;
  logic [2:0] f_err;

  uart_rx_loader #(.BITS_PER_WORD(8), .W_OUT(W_OUT), .NUM_DEST(NUM_DEST), .TIMEOUT_CLKS(TIMEOUT_CLKS)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_dest(m_dest), .m_last(m_last), .f_valid(f_valid), .f_err(f_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [W_OUT-1:0] d; logic [1:0] dest; logic last;} word_t;
  typedef struct {logic [2:0] err; int at;} stat_t;

  word_t wq[$];
  stat_t sq[$];
  word_t ew;
  stat_t es;
  logic [7:0] fb[$];
  int cyc = 0;
  int checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (!rst && m_valid && m_ready) begin
      if (wq.size() == 0) check("extra_word", 32'(m_data), 32'hdead_beef);
      else begin
        ew = wq.pop_front();
        check("m_data", 32'(m_data), 32'(ew.d));
        check("m_dest", 32'(m_dest), 32'(ew.dest));
        check("m_last", 32'(m_last), 32'(ew.last));
      end
    end
    if (f_valid) begin
      if (sq.size() == 0) check("extra_fvalid", 32'(f_err), 32'hdead_beef);
      else begin
        es = sq.pop_front();
        check("f_err", 32'(f_err), 32'(es.err));
        if (es.at >= 0) check("f_latency", 32'(cyc), 32'(es.at));
      end
    end
  end

  task automatic send(input logic [7:0] b, output int at);
    @(negedge clk);
    s_valid = 1'b1;
    s_data = b;
    at = cyc + 1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Reference model: expected words and frame status are derived from fb alone.
  task automatic put_frame();
    logic [7:0] x;
    logic [1:0] d;
    int len, at;
    word_t w;
    d = fb[0][7:6];
    len = int'(fb[0][5:0]) + 1;
    x = '0;
    foreach (fb[i]) x ^= fb[i];
    if (int'(d) < NUM_DEST)
      for (int k = 0; k < len; k++) begin
        w.d = '0;
        for (int b = 0; b < BYTES; b++) w.d[8*b +: 8] = fb[1 + BYTES*k + b];
        w.dest = d;
        w.last = (k == len - 1);
        wq.push_back(w);
      end
    for (int i = 0; i < fb.size(); i++) send(fb[i], at);
    sq.push_back('{err: int'(d) >= NUM_DEST ? 3'(ERR_BAD_DEST) : x == 0 ? 3'(ERR_OK) : 3'(ERR_CHECKSUM), at: at});
  endtask

  task automatic settle(input string tag);
    repeat (4) @(negedge clk);
    check({tag, "_words_pending"}, 32'(wq.size()), 0);
    check({tag, "_status_pending"}, 32'(sq.size()), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int at;
    repeat (3) @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_f_valid", 32'(f_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_m_data", 32'(m_data), 0);
    rst = 1'b0;

    fb = '{8'h41, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h36};
    put_frame();
    settle("s1");

    fb = '{8'h41, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00};
    put_frame();
    settle("s2");

    send(8'h00, at);
    send(8'h11, at);
    sq.push_back('{err: 3'(ERR_TIMEOUT), at: -1});
    repeat (TIMEOUT_CLKS + 8) @(negedge clk);
    settle("s3");

    m_ready = 1'b0;
    wq.push_back('{d: 24'hCCBBAA, dest: 2'd0, last: 1'b0});
    foreach (fb[i]) ;
    fb = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    for (int i = 0; i < fb.size(); i++) send(fb[i], at);
    send(8'hFF, at);
    sq.push_back('{err: 3'(ERR_OVERRUN), at: at});
    repeat (3) @(negedge clk);
    check("s4_hold_valid", 32'(m_valid), 1);
    check("s4_hold_data", 32'(m_data), 32'hCCBBAA);
    m_ready = 1'b1;
    @(negedge clk);
    settle("s4");
    check("s4_valid_dropped", 32'(m_valid), 0);

    fb = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'hC2};
    put_frame();
    settle("s5_bad");
    fb = '{8'h41, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h36};
    put_frame();
    settle("s5_good");

    wq.push_back('{d: 24'h332211, dest: 2'd1, last: 1'b0});
    fb = '{8'h41, 8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < fb.size(); i++) send(fb[i], at);
    rst = 1'b1;
    @(negedge clk);
    check("s6_m_valid", 32'(m_valid), 0);
    check("s6_f_valid", 32'(f_valid), 0);
    check("s6_busy", 32'(busy), 0);
    check("s6_m_data", 32'(m_data), 0);
    check("s6_f_err", 32'(f_err), 0);
    rst = 1'b0;
    fb = '{8'h41, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h36};
    put_frame();
    settle("s6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
